download_sdram_writer: RTL and testbench

//  Sits directly downstream of the download stage. Takes its byte-write stream (wr/addr/data/downloading),

---
 rtl/dl_pkg.sv | 18 +
 rtl/dl_fifo.sv | 49 ++++
 rtl/download_sdram_writer.sv | 128 ++++++++++++
 tb/tb_download_sdram_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared types for the download-to-SDRAM write path.
package dl_pkg;

  localparam int DL_ADDR_W     = 25;
  localparam int DL_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } dl_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } dl_state_t;

endpackage

// File: rtl/dl_fifo.sv
// Single-clock FIFO of download entries. Pointers carry one extra wrap bit
// so full and empty can be told apart without a separate counter. A push
// while full is only accepted when a pop frees a slot in the same cycle.
module dl_fifo
  import dl_pkg::*;
#(
  parameter int  DEPTH   = DL_FIFO_DEPTH,
  parameter type entry_t = dl_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           wr_en;
  entry_t         mem [DEPTH];

  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = push & (~full | pop);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Advance pointers; both may move in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (pop)   rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/download_sdram_writer.sv
// Buffers the download stage's byte writes and replays them one at a time
// to the SDRAM controller using a req/ack handshake. Holds the CPU until
// the download is over and every buffered byte has been written.
module download_sdram_writer
  import dl_pkg::*;
#(
  parameter int FIFO_DEPTH = DL_FIFO_DEPTH,
  parameter int ADDR_W     = DL_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              dl_downloading,
  output logic              sdram_req,
  output logic              sdram_we,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  input  logic              sdram_ack,
  output logic              cpu_wait,
  output logic              overflow
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  dl_state_t         state;
  dl_state_t         state_next;
  logic              load;
  logic              prev_wr;
  logic              prev_downloading;
  logic [ADDR_W-1:0] last_addr;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  entry_t            fifo_din;
  entry_t            fifo_head;

  // A new byte is a fresh strobe, or a held strobe that moved to a new address.
  assign push     = dl_wr & (~prev_wr | (dl_addr != last_addr));
  assign pop      = (state == REQ) & sdram_ack;
  assign fifo_din = '{addr: dl_addr, data: dl_data};

  assign sdram_req = (state == REQ);
  assign sdram_we  = sdram_req;

  dl_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Remember the previous strobe/download level and the last captured address.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_wr          <= 1'b0;
      prev_downloading <= 1'b0;
      last_addr        <= '0;
    end else begin
      prev_wr          <= dl_wr;
      prev_downloading <= dl_downloading;
      if (push) last_addr <= dl_addr;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: issue the head entry, wait for ack, then one re-arm cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = REQ;
        end
      end
      REQ:     if (sdram_ack) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the head entry as the request payload so it stays stable during REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      sdram_addr <= '0;
      sdram_din  <= '0;
    end else if (load) begin
      sdram_addr <= fifo_head.addr;
      sdram_din  <= fifo_head.data;
    end
  end

  // Sticky drop flag, cleared by a new download starting; a drop wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else begin
      if (dl_downloading && !prev_downloading) overflow <= 1'b0;
      if (push && fifo_full && !pop)           overflow <= 1'b1;
    end
  end

  // CPU stays held while downloading, while bytes are buffered or a write is in flight.
  always_ff @(posedge clk) begin
    if (reset) cpu_wait <= 1'b0;
    else       cpu_wait <= dl_downloading | ~fifo_empty | (state != IDLE);
  end

endmodule

// File: tb/tb_download_sdram_writer.sv
// Directed bench for download_sdram_writer. Expected SDRAM writes are queued
// when stimulus is driven and popped when a request appears on the port.
module tb_download_sdram_writer;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_downloading;
  logic        sdram_req;
  logic        sdram_we;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_ack;
  logic        cpu_wait;
  logic        overflow;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  download_sdram_writer #(
    .FIFO_DEPTH (8),
    .ADDR_W     (25)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dl_wr          (dl_wr),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .dl_downloading (dl_downloading),
    .sdram_req      (sdram_req),
    .sdram_we       (sdram_we),
    .sdram_addr     (sdram_addr),
    .sdram_din      (sdram_din),
    .sdram_ack      (sdram_ack),
    .cpu_wait       (cpu_wait),
    .overflow       (overflow)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [24:0] addr,
                               input logic [7:0] data, input logic expect_push);
    exp_t e;
    dl_wr   = wr;
    dl_addr = addr;
    dl_data = data;
    if (expect_push) begin
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic waitReq(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (sdram_req) found = 1'b1;
      else           tick();
    end
    checkOutput("req_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic checkRequest(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_addr"}, {7'd0, sdram_addr}, {7'd0, e.addr});
      checkOutput({tag, "_data"}, {24'd0, sdram_din}, {24'd0, e.data});
      checkOutput({tag, "_we"}, {31'd0, sdram_we}, 32'd1);
    end
  endtask

  // Wait for a request, check it, then ack it 'delay' clocks after it was seen.
  task automatic serviceRequest(input string tag, input int delay);
    bit          found;
    logic [24:0] held_addr;
    waitReq(found);
    if (found) begin
      checkRequest(tag);
      held_addr = sdram_addr;
      for (int i = 1; i < delay; i++) begin
        tick();
        checkOutput({tag, "_hold_req"}, {31'd0, sdram_req}, 32'd1);
        checkOutput({tag, "_hold_addr"}, {7'd0, sdram_addr}, {7'd0, held_addr});
      end
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      checkOutput({tag, "_req_after_ack"}, {31'd0, sdram_req}, 32'd0);
    end
  endtask

  task automatic checkNoRequest(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (sdram_req) seen++;
      tick();
    end
    checkOutput({tag, "_stray_req"}, seen, 32'd0);
    checkOutput({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    bit found;
    exp_t e;

    reset          = 1'b1;
    dl_wr          = 1'b0;
    dl_addr        = '0;
    dl_data        = '0;
    dl_downloading = 1'b0;
    sdram_ack      = 1'b0;
    tick();
    tick();
    checkOutput("rst_req", {31'd0, sdram_req}, 32'd0);
    checkOutput("rst_we", {31'd0, sdram_we}, 32'd0);
    checkOutput("rst_addr", {7'd0, sdram_addr}, 32'd0);
    checkOutput("rst_din", {24'd0, sdram_din}, 32'd0);
    checkOutput("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single write, ack three clocks after req, then cpu_wait release
    dl_downloading = 1'b1;
    applyStimulus(1'b1, 25'h010000, 8'hA5, 1'b1);
    dl_wr          = 1'b0;
    dl_downloading = 1'b0;
    serviceRequest("single", 3);
    checkOutput("single_cpu_wait_gap", {31'd0, cpu_wait}, 32'd1);
    tick();
    checkOutput("single_cpu_wait_idle", {31'd0, cpu_wait}, 32'd1);
    tick();
    checkOutput("single_cpu_wait_fall", {31'd0, cpu_wait}, 32'd0);
    checkNoRequest("single", 6);

    // 2: strobe held six clocks at one address pushes once
    dl_downloading = 1'b1;
    applyStimulus(1'b1, 25'h000100, 8'h11, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 25'h000100, 8'h11, 1'b0);
    dl_wr = 1'b0;
    serviceRequest("held", 1);
    checkNoRequest("held", 8);

    // 3: held strobe with an address step pushes both bytes in order
    applyStimulus(1'b1, 25'h0083E9, 8'h34, 1'b1);
    applyStimulus(1'b1, 25'h0083EA, 8'h12, 1'b1);
    dl_wr = 1'b0;
    serviceRequest("pair_lo", 1);
    serviceRequest("pair_hi", 2);
    checkNoRequest("pair", 6);

    // 4: no acks, ten distinct bytes; only the first eight survive
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 25'(32'h200 + i), 8'(32'h50 + i), i < 8);
      checkOutput("ovf_step", {31'd0, overflow}, {31'd0, i >= 8});
    end
    dl_wr = 1'b0;
    tick();
    tick();
    checkOutput("ovf_first_req_held", {31'd0, sdram_req}, 32'd1);
    for (int i = 0; i < 8; i++) serviceRequest("ovf_drain", 1);
    checkNoRequest("ovf", 8);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5: push on the ack cycle while full is accepted without overflow
    dl_downloading = 1'b0;
    tick();
    dl_downloading = 1'b1;
    tick();
    checkOutput("full_ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 25'(32'h300 + i), 8'(32'h60 + i), 1'b1);
    dl_wr = 1'b0;
    tick();
    checkOutput("full_no_ovf", {31'd0, overflow}, 32'd0);
    waitReq(found);
    if (found) checkRequest("full_first");
    e.addr    = 25'h000308;
    e.data    = 8'h68;
    sb.push_back(e);
    dl_wr     = 1'b1;
    dl_addr   = e.addr;
    dl_data   = e.data;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    checkOutput("full_concurrent_ovf", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b1, 25'h000309, 8'h69, 1'b0);
    dl_wr = 1'b0;
    checkOutput("full_still_full", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) serviceRequest("full_drain", 1);
    checkNoRequest("full", 6);

    // 6: reset while a request is pending flushes everything
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 25'(32'h400 + i), 8'(32'h70 + i), 1'b0);
    dl_wr = 1'b0;
    waitReq(found);
    reset          = 1'b1;
    dl_downloading = 1'b0;
    tick();
    reset = 1'b0;
    checkOutput("rst_mid_req", {31'd0, sdram_req}, 32'd0);
    checkOutput("rst_mid_we", {31'd0, sdram_we}, 32'd0);
    checkOutput("rst_mid_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    checkOutput("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    checkNoRequest("rst_mid", 12);
    checkOutput("rst_mid_cpu_wait_after", {31'd0, cpu_wait}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
